serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. Sequences one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands, replacing a WIDTH-cell ripple chain with one cell, a carry flop and shift registers. Sits beside the ripple-carry adders in the 4-bit adder area as the area-minimal alternative. Uses a start/done handshake.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- sub  input  1  subtract request; present only with SERIAL_ADD_SUB_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; marks sum/cout valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. When start=1 at an edge:
  - load shift registers opA<=a and opB<=b
  - carry<=cin
  - bit counter <= 0
  - go to RUN.
- RUN: busy=1. At each edge:
  - Full-adder cell computes s=opA[0]^opB[0]^carry and c=majority(opA[0],opB[0],carry).
  - s shifts into the result shift register from the MSB side; opA and opB shift right.
  - carry<=c; counter increments.
  - On the edge that processes bit WIDTH-1, go to DONE and register sum<=final result and cout<=c.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 is accepted here exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- sum and cout change only on completion. They hold the last result through later RUN phases until the next completion.
- start while busy=1 is ignored; it is not queued. a, b and cin may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Bit counter width is clog2(WIDTH)+1.
- WIDTH=1: exactly one RUN cycle.
- Reset (any state, including mid-RUN):
  - state IDLE
  - busy=0, done=0, sum=0, cout=0
  - shift registers, carry and counter cleared
  - an aborted operation produces no done.

## Timing
- Acceptance edge E0: busy=1 from E0.
- Bit i is processed at edge E(i+1), for i=0..WIDTH-1.
- After E(WIDTH): busy=0, done=1, sum/cout valid.
- After E(WIDTH+1): done=0 unless a new operation started at that edge.
- Latency from start edge to done: WIDTH+1 edges. Minimum back-to-back issue interval: WIDTH+1 cycles (start held high).
- Outputs are all registered. There is no combinational path from inputs to outputs.
- rst_n assertion takes effect immediately. Deassertion is synchronised externally; the first edge after deassertion may accept start.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is captured with the operands.
  - sub=1 loads opB<=~b and carry<=1, ignoring cin.
  - Result: sum = a - b modulo 2^WIDTH; cout=1 means no borrow (a>=b unsigned).
  - sub=0 behaves exactly as an add.
- SERIAL_ADD_SUB_EN undefined: the sub port is absent; add only; no extra logic.

## Test plan
- WIDTH=4, a=9, b=5, cin=0, start one cycle:
  - busy high for 4 cycles
  - done pulses at E5
  - sum=14, cout=0.
- a=15, b=1, cin=1: sum=1, cout=1. Also run a=0, b=0, cin=0: sum=0, cout=0, done still at E5.
- Start with a=3, b=4; pulse start again at E2 with a=15, b=15:
  - second request ignored
  - single done at E5 with sum=7, cout=0.
- Start a=6, b=7; assert rst_n low after E2:
  - busy=0, sum=0, cout=0 immediately
  - no done pulse
  - a following 2+2 completes with sum=4.
- start held high with a=1, b=2, cin=0:
  - done at E5, E10, E15
  - sum=3 each time, busy low only in the DONE cycles.
- With SERIAL_ADD_SUB_EN:
  - sub=1, a=3, b=5 gives sum=14 (0xE), cout=0.
  - sub=1, a=7, b=2 gives sum=5, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Adds two WIDTH-bit operands plus a carry-in with one full-adder cell over
// WIDTH cycles. The adder is started with start and signals completion with a
// one-cycle done pulse.
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the sub port. With sub=1
// the block computes a - b. cout=1 then means no borrow.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled while busy=0
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   sub    subtract request (SERIAL_ADD_SUB_EN only)
//   busy   high while bits are being processed
//   done   one-cycle pulse, sum/cout valid
//   sum    registered result
//   cout   registered carry-out of bit WIDTH-1
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic [WIDTH-1:0] opb_load;
  logic             carry, carry_load;
  logic [CW-1:0]    cnt;
  logic             load, shift, last;
  logic             fa_s, fa_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath control strobes
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    last  = 1'b0;
    case (state)
      S_IDLE, S_DONE: load = start;
      S_RUN: begin
        shift = 1'b1;
        last  = (cnt == CW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  // Subtraction loads the inverted B operand and forces the carry-in, which gives two's complement.
`ifdef SERIAL_ADD_SUB_EN
  assign opb_load   = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign opb_load   = b;
  assign carry_load = cin;
`endif

  // Single full-adder cell on the LSBs of the operand shift registers
  assign fa_s = opa[0] ^ opb[0] ^ carry;
  assign fa_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  // New sum bit enters from the MSB side; the WIDTH+1-bit form also covers WIDTH=1
  assign res_nxt = WIDTH'({fa_s, res} >> 1);

  // Operand/result shift registers, carry, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (load) begin
        opa   <= a;
        opb   <= opb_load;
        carry <= carry_load;
        cnt   <= '0;
      end else if (shift) begin
        opa   <= opa >> 1;
        opb   <= opb >> 1;
        res   <= res_nxt;
        carry <= fa_c;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= res_nxt;
          cout <= fa_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl.
// The stimulus process issues requests. A reference model accepts each request
// on a clock edge when the model is not busy, and then queues the expected
// {cout,sum} together with the edge on which the result is due. A separate
// monitor process takes an entry from the queue whenever done is seen. The
// monitor also checks busy, done and the held sum/cout on every cycle.
module tb_serial_add_ctrl;
  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  exp_t         q[$];
  exp_t         mon_e;
  int           cur      = 0;
  int           last_acc = 0;
  bit           active   = 1'b0;
  logic [W-1:0] msum     = '0;
  logic         mcout    = 1'b0;
  bit           eb, ed;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cur);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input int due);
    exp_t   e;
    longint t;
    if (sb) begin
      e.s = x - y;
      e.c = (x >= y);
    end else begin
      t   = longint'(x) + longint'(y) + longint'(ci);
      e.s = W'(t);
      e.c = t[W];
    end
    e.due = due;
    return e;
  endfunction

  // Model: a request is taken when no operation is active or the previous one
  // has reached its done cycle. The result is due WIDTH edges later.
  always @(posedge clk) begin
    cur++;
    if (rst_n && start && (!active || (cur - last_acc) > int'(W))) begin
      active   = 1'b1;
      last_acc = cur;
      q.push_back(model(a, b, cin, sub, cur + int'(W)));
    end
  end

  // Monitor: samples the DUT on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() != 0 && q[0].due < cur) begin
        checks++;
        failures++;
        $display("FAIL done_missing: no done by edge %0d, due edge %0d", cur, q[0].due);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done: done=1 at edge %0d, none expected", cur);
        end else begin
          mon_e = q.pop_front();
          chk("done_edge", 64'(cur), 64'(mon_e.due));
          chk("sum", 64'(sum), 64'(mon_e.s));
          chk("cout", 64'(cout), 64'(mon_e.c));
          msum  = mon_e.s;
          mcout = mon_e.c;
        end
      end
      eb = active && (cur - last_acc) < int'(W);
      ed = active && (cur - last_acc) == int'(W);
      chk("busy", 64'(busy), 64'(eb));
      chk("done", 64'(done), 64'(ed));
      chk("sum_hold", 64'(sum), 64'(msum));
      chk("cout_hold", 64'(cout), 64'(mcout));
    end
  end

  task automatic flush_model();
    q.delete();
    active = 1'b0;
    msum   = '0;
    mcout  = 1'b0;
  endtask

  // Single-cycle request, then operands are scrambled and the bench idles for gap cycles
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                    input logic sb, input int gap);
    @(negedge clk); #1;
    start = 1'b1; a = x; b = y; cin = ci; sub = sb;
    @(negedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    flush_model();
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic sb;
    #1;
    reset_now();

    // Directed adds
    op(4'd9, 4'd5, 1'b0, 1'b0, W + 1);
    op(4'd15, 4'd1, 1'b1, 1'b0, W + 1);
    op(4'd0, 4'd0, 1'b0, 1'b0, W + 1);

    // A second start while busy is ignored
    @(negedge clk); #1;
    start = 1'b1; a = 4'd3; b = 4'd4; cin = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    start = 1'b1; a = 4'd15; b = 4'd15; cin = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset in the middle of an operation, then a fresh add
    op(4'd6, 4'd7, 1'b0, 1'b0, 1);
    #1;
    reset_now();
    op(4'd2, 4'd2, 1'b0, 1'b0, W + 1);

    // start held high: back-to-back operations
    @(negedge clk); #1;
    start = 1'b1; a = 4'd1; b = 4'd2; cin = 1'b0;
    repeat (3 * (W + 1)) @(negedge clk);
    #1 start = 1'b0;
    repeat (W + 2) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    op(4'd3, 4'd5, 1'b0, 1'b1, W + 1);
    op(4'd7, 4'd2, 1'b1, 1'b1, W + 1);
`endif

    // Random requests of random length; operands change every cycle while start is held
    for (int i = 0; i < 80; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      @(negedge clk); #1;
      start = 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = sb;
        @(negedge clk); #1;
      end
      start = 1'b0; sub = 1'b0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (W + 3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
